// File: rtl/instruction_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_rom_pkg
// Description : Shared constants and types for the instruction ROM: the NOP
//               word returned while no program is served, and the FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_rom_pkg;

    // addnv reg0, reg0 with bit 15 clear: a harmless idle instruction
    localparam logic [15:0] ROM_NOP = 16'h42C0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } rom_state_t;

endpackage
`default_nettype wire

// File: rtl/rom_storage_sp.sv
`default_nettype none
// ============================================================================
// Module      : rom_storage_sp
// Description : Single-port synchronous RAM with registered read. One address
//               port serves both the load writes and the fetch reads, since
//               the owner never needs both in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_storage_sp
    import instruction_rom_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rdata;

    // Write on enable, always register the addressed word for reading
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/instruction_rom.sv
`default_nettype none
// ============================================================================
// Module      : instruction_rom
// Description : Program memory for the instruction processor fetch port.
//               A program is streamed in over a valid/ready port; NOP words
//               are returned until a complete program is present.
//               Optional: INSTRUCTION_ROM_CHECKSUM_EN adds loadChecksum, the
//               modulo-2^WIDTH sum of the words accepted by the latest load.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_rom
    import instruction_rom_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ROMAddress,
    output logic [WIDTH-1:0] ROMData,
    input  logic             loadStart,
    input  logic             loadValid,
    input  logic [WIDTH-1:0] loadData,
    input  logic             loadLast,
    output logic             loadReady,
    output logic             loadDone,
    output logic             running
`ifdef INSTRUCTION_ROM_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] loadChecksum
`endif
);

    localparam logic [WIDTH-1:0] c_nop_word = WIDTH'(ROM_NOP);

    rom_state_t            r_state;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic                  r_done;
    logic                  r_serve;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_final;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [WIDTH-1:0]      w_ram_rdata;

    // loadStart is ignored while a load is already in progress; reset wins
    assign w_start    = !reset && loadStart && (r_state != LOAD);
    // Accept only in LOAD and never under reset, so a reset cycle writes nothing
    assign w_accept   = !reset && loadValid && (r_state == LOAD);
    // Explicit last flag, or the top address acting as an implicit last
    assign w_final    = w_accept && (loadLast || (r_ptr == '1));
    // Addresses past the storage depth fetch NOP instead of aliasing
    assign w_in_range = (ROMAddress >> DEPTH_LOG2) == '0;
    assign w_ram_addr = w_accept ? r_ptr : ROMAddress[DEPTH_LOG2-1:0];

    rom_storage_sp #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_storage (
        .clk     (clock),
        .i_we    (w_accept),
        .i_addr  (w_ram_addr),
        .i_wdata (loadData),
        .o_rdata (w_ram_rdata)
    );

    // Load FSM: state, write pointer and the one-cycle completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_state <= LOAD;
                r_ptr   <= '0;
            end else if (w_accept) begin
                r_ptr <= r_ptr + 1'b1;
                if (w_final) begin
                    r_state <= RUN;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    // Qualify the registered RAM word; a loadStart in RUN drops the program at once
    always_ff @(posedge clock) begin
        if (reset) begin
            r_serve <= 1'b0;
        end else begin
            r_serve <= (r_state == RUN) && !loadStart && w_in_range;
        end
    end

    assign ROMData   = r_serve ? w_ram_rdata : c_nop_word;
    assign loadReady = (r_state == LOAD);
    assign running   = (r_state == RUN);
    assign loadDone  = r_done;

`ifdef INSTRUCTION_ROM_CHECKSUM_EN
    logic [WIDTH-1:0] r_checksum;

    // Running sum of accepted words, cleared when a new load begins
    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + loadData;
        end
    end

    assign loadChecksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_rom.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_rom
// Description : Self-checking bench for instruction_rom: directed scenarios
//               followed by randomized loads and fetches, compared against a
//               program-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_rom;

    localparam int          WIDTH = 16;
    localparam int          DL    = 10;
    localparam int          DEPTH = 1 << DL;
    localparam logic [15:0] NOP   = 16'h42C0;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic [15:0] ROMAddress = '0;
    logic        loadStart  = 1'b0;
    logic        loadValid  = 1'b0;
    logic [15:0] loadData   = '0;
    logic        loadLast   = 1'b0;
    logic [15:0] ROMData;
    logic        loadReady;
    logic        loadDone;
    logic        running;
`ifdef INSTRUCTION_ROM_CHECKSUM_EN
    logic [15:0] loadChecksum;
`endif

    instruction_rom #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) dut (
        .clock        (clock),
        .reset        (reset),
        .ROMAddress   (ROMAddress),
        .ROMData      (ROMData),
        .loadStart    (loadStart),
        .loadValid    (loadValid),
        .loadData     (loadData),
        .loadLast     (loadLast),
        .loadReady    (loadReady),
        .loadDone     (loadDone),
        .running      (running)
`ifdef INSTRUCTION_ROM_CHECKSUM_EN
        ,
        .loadChecksum (loadChecksum)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the program image and what the block is doing with it
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_mode;          // 0 = no program, 1 = loading, 2 = serving
    int          m_ptr;
    logic [15:0] m_sum;
    bit          m_done;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the current inputs, step the model, then compare
    task automatic cycle();
        logic [15:0] exp_data;
        bit          data_known;
        int          a;
        a = int'(ROMAddress);
        if (reset || m_mode != 2 || loadStart || a >= DEPTH) begin
            exp_data   = NOP;
            data_known = 1'b1;
        end else begin
            exp_data   = m_mem[a];
            data_known = m_known[a];
        end
        m_done = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_ptr  = 0;
            m_sum  = '0;
        end else if (loadStart && m_mode != 1) begin
            m_mode = 1;
            m_ptr  = 0;
            m_sum  = '0;
        end else if (m_mode == 1 && loadValid) begin
            m_mem[m_ptr]   = loadData;
            m_known[m_ptr] = 1'b1;
            m_sum          = m_sum + loadData;
            if (loadLast || m_ptr == DEPTH - 1) begin
                m_mode = 2;
                m_done = 1'b1;
            end
            m_ptr++;
        end
        @(posedge clock);
        #1;
        if (data_known) check("ROMData", ROMData, exp_data);
        check("loadReady", 16'(loadReady), 16'(m_mode == 1));
        check("running",   16'(running),   16'(m_mode == 2));
        check("loadDone",  16'(loadDone),  16'(m_done));
`ifdef INSTRUCTION_ROM_CHECKSUM_EN
        check("loadChecksum", loadChecksum, m_sum);
`endif
    endtask

    task automatic start_load();
        loadStart = 1'b1;
        cycle();
        loadStart = 1'b0;
    endtask

    task automatic put_word(input logic [15:0] d, input bit last, input int gap);
        loadValid = 1'b1;
        loadData  = d;
        loadLast  = last;
        cycle();
        loadValid = 1'b0;
        loadLast  = 1'b0;
        loadData  = 16'($urandom);
        repeat (gap) cycle();
    endtask

    task automatic fetch(input logic [15:0] a);
        ROMAddress = a;
        cycle();
    endtask

    initial begin
        int n;
        logic [15:0] addr;
        m_mode = 0;
        m_ptr  = 0;
        m_sum  = '0;
        m_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset state, then fetches with no program present
        repeat (2) cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) fetch(16'(i));

        // Back-to-back three-word load and fetch-back
        start_load();
        put_word(16'h1111, 1'b0, 0);
        put_word(16'h2222, 1'b0, 0);
        put_word(16'h3333, 1'b1, 0);
        for (int i = 0; i < 4; i++) fetch(16'(i % 3));

        // Same program with two idle cycles between words
        start_load();
        put_word(16'h1111, 1'b0, 2);
        put_word(16'h2222, 1'b0, 2);
        put_word(16'h3333, 1'b1, 2);
        fetch(16'hFFFF);
        fetch(16'h0001);
        fetch(16'h0400);
        fetch(16'h03FF);
        fetch(16'h0002);

        // Reset part-way through a load, then a fresh load
        start_load();
        put_word(16'hAAAA, 1'b0, 0);
        put_word(16'hBBBB, 1'b0, 0);
        reset = 1'b1;
        loadValid = 1'b1;
        loadData  = 16'hCCCC;
        cycle();
        reset = 1'b0;
        loadValid = 1'b0;
        for (int i = 0; i < 3; i++) fetch(16'(i));
        start_load();
        put_word(16'h0A0A, 1'b0, 1);
        put_word(16'h0B0B, 1'b1, 0);
        fetch(16'h0000);
        fetch(16'h0001);
        fetch(16'h0002);

        // Randomized loads (with ignored loadStart pulses) and fetches
        for (int it = 0; it < 8; it++) begin
            start_load();
            n = int'($urandom_range(1, 24));
            for (int k = 0; k < n; k++) begin
                ROMAddress = 16'($urandom_range(0, 40));
                loadStart  = ($urandom_range(0, 7) == 0);
                put_word(16'($urandom), (k == n - 1), int'($urandom_range(0, 2)));
                loadStart  = 1'b0;
            end
            for (int f = 0; f < 30; f++) begin
                if ($urandom_range(0, 3) == 0) addr = 16'($urandom_range(DEPTH, 65535));
                else                           addr = 16'($urandom_range(0, n - 1));
                loadValid = $urandom_range(0, 1) == 1;
                loadData  = 16'($urandom);
                fetch(addr);
            end
            loadValid = 1'b0;
        end

        // Full-depth load without loadLast: top address ends the load
        start_load();
        for (int k = 0; k < DEPTH; k++) put_word(16'($urandom), 1'b0, 0);
        fetch(16'h03FF);
        fetch(16'h0000);
        fetch(16'h0200);
        fetch(16'h0400);

        // loadStart during RUN with a valid address in flight
        ROMAddress = 16'h0005;
        start_load();
        fetch(16'h0005);
        put_word(16'h5555, 1'b1, 0);
        fetch(16'h0000);
        fetch(16'h0000);

`ifdef INSTRUCTION_ROM_CHECKSUM_EN
        // Wrap-around sum, then cleared by a new load
        start_load();
        put_word(16'hFFFF, 1'b0, 0);
        put_word(16'h0002, 1'b1, 0);
        check("checksum_wrap", loadChecksum, 16'h0001);
        fetch(16'h0000);
        start_load();
        check("checksum_clear", loadChecksum, 16'h0000);
        put_word(16'h1234, 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_rom.md
# instruction_rom

Program memory serving the instruction processor's fetch port. Each cycle the processor presents `ROMAddress`; this block returns the addressed word on `ROMData` one clock later. Before execution, a program is streamed in through a valid/ready load port. Until a complete program is present, and while one is loading, the block returns NOP words so the processor idles harmlessly.

## Interface
Parameters:
- `WIDTH`, 16: word width; must match the processor's `ROMData`/`ROMAddress` width.
- `DEPTH_LOG2`, 10: storage depth is 2^DEPTH_LOG2 words.

Ports:
- `clock`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ROMAddress`  in  WIDTH: fetch address, driven by the processor's ip register.
- `ROMData`  out  WIDTH: registered instruction word returned to the processor.
- `loadStart`  in  1: one-cycle pulse that begins a program load.
- `loadValid`  in  1: `loadData` holds a valid word.
- `loadData`  in  WIDTH: program word to store.
- `loadLast`  in  1: qualifies the final word of the program.
- `loadReady`  out  1: block accepts a word this cycle.
- `loadDone`  out  1: one-cycle pulse when a load completes.
- `running`  out  1: a valid program is present and being served.

## Operation
- NOP word: `16'h42C0`, which encodes `addnv reg0, reg0` with bit 15 = 0.
- States:
  - EMPTY: entered on reset; no program present.
  - LOAD: program words are being accepted.
  - RUN: program served to the processor.
- Transitions:
  - EMPTY→LOAD and RUN→LOAD on `loadStart`. On entry, the write pointer clears to 0.
  - `loadStart` is ignored while in LOAD.
  - LOAD→RUN after a word is accepted with `loadLast`=1, or after the word at pointer 2^DEPTH_LOG2−1 is accepted (implicit last).
  - `loadDone` pulses in the cycle after that final accept.
- Load handshake:
  - `loadReady` = 1 exactly when the state is LOAD.
  - A word is accepted when `loadValid` && `loadReady`: `mem[ptr]` ← `loadData`, then ptr increments.
  - Idle cycles (`loadValid`=0) are permitted and change nothing.
- Fetch behaviour:
  - In RUN, `ROMData` ← `mem[ROMAddress[DEPTH_LOG2-1:0]]` if `ROMAddress` < 2^DEPTH_LOG2; otherwise `ROMData` ← NOP (no aliasing).
  - In EMPTY or LOAD, `ROMData` ← NOP regardless of `ROMAddress`.
- Words at addresses not written by the current load keep their previous contents. After the first load they are unspecified.
- Reset mid-load: the state returns to EMPTY and the partial program is never served. Memory contents are not cleared.
- `loadStart` during RUN: the program is discarded immediately. NOP is returned from the next cycle.

## Timing
- Reset values:
  - `ROMData` = NOP.
  - `loadReady` = 0.
  - `loadDone` = 0.
  - `running` = 0.
  - Write pointer = 0.
- Fetch latency: exactly 1 cycle, address sampled at edge n, data valid after edge n+1. Back-to-back addresses give one word per cycle.
- `loadStart` at edge n: `loadReady` = 1 from edge n+1, and `ROMData` = NOP from edge n+1.
- Final accept at edge n:
  - `loadDone` = 1 and `running` = 1 after edge n+1.
  - `loadReady` = 0 after edge n+1.
  - The first real fetch word appears after edge n+2.
- `reset` has priority over `loadStart`, which has priority over the handshake in the same cycle.

## Configuration
- `INSTRUCTION_ROM_CHECKSUM_EN`:
  - Defined: adds output `loadChecksum` [WIDTH-1:0]. It is cleared to 0 on reset and on `loadStart`, and accumulates the sum of accepted words modulo 2^WIDTH on every accept. It holds its value in RUN.
  - Undefined: the port and adder are absent, and behaviour is otherwise identical.

## Structure
- Shared package `instruction_rom_pkg`:
  - `ROM_NOP` constant (`16'h42C0`).
  - State typedef {EMPTY, LOAD, RUN}.
- Sub-module `rom_storage_sp`: single-port synchronous RAM with registered read, sized by `DEPTH_LOG2`. Single-port suffices because reads and writes never occur in the same state.
- Top level contains the FSM, write pointer, range check, NOP mux and the optional checksum.

## Test plan
- Reset, then `ROMAddress`=0..3 with no load → `ROMData`=`16'h42C0` every cycle; `running`=0; `loadReady`=0.
- `loadStart`, then words `16'h1111`, `16'h2222`, `16'h3333` (last) with `loadValid` always high → `loadDone` pulses once; fetching addresses 0,1,2 returns `16'h1111`, `16'h2222`, `16'h3333` one cycle later.
- Same load with `loadValid` gaps of 2 cycles between words → identical contents; `loadReady` stays 1 through the gaps.
- After the load, `ROMAddress`=`16'hFFFF` with `DEPTH_LOG2`=10 → `ROMData`=NOP; `ROMAddress`=1 → `16'h2222`.
- Reset asserted after 2 of 3 words → state EMPTY; `ROMData`=NOP; `loadDone` never pulses; a fresh load then succeeds.
- With `INSTRUCTION_ROM_CHECKSUM_EN` defined: load `16'hFFFF`, `16'h0002` → `loadChecksum`=`16'h0001`; a new `loadStart` clears it to 0.
